// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold-timeout preemption
// Grants one owner of a shared 8:1 mux path; gnt, sel and busy are registered together.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       preempt_q, preempt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] ptr_q, ptr_d;

  logic [7:0] others;
  logic       owner_req;
  logic       idle_found, next_found;
  logic [2:0] idle_idx, next_idx;

  // Circular priority search: returns {found, index} of the first set bit at or after start.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

  always_comb begin
    others                 = req & ~gnt_q;
    owner_req              = |(req & gnt_q);
    {idle_found, idle_idx} = rr_pick(req, ptr_q);
    {next_found, next_idx} = rr_pick(others, sel_q + 3'd1);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_found) begin
          state_d = ST_OWNED;
          gnt_d   = onehot8(idle_idx);
          sel_d   = idle_idx;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          ptr_d   = idle_idx + 3'd1;
        end else begin
          gnt_d  = 8'd0;
          sel_d  = 3'd0;
          busy_d = 1'b0;
        end
      end
      ST_OWNED: begin
        if (!owner_req) begin
          if (next_found) begin
            gnt_d = onehot8(next_idx);
            sel_d = next_idx;
            cnt_d = 8'd0;
            ptr_d = next_idx + 3'd1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 8'd0;
            sel_d   = 3'd0;
            busy_d  = 1'b0;
            cnt_d   = 8'd0;
          end
        end else if ((cnt_q == HOLD_LAST) && next_found) begin
          // Owner has used its full hold budget while someone else waits.
          gnt_d     = onehot8(next_idx);
          sel_d     = next_idx;
          cnt_d     = 8'd0;
          ptr_d     = next_idx + 3'd1;
          preempt_d = 1'b1;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'd0;
        sel_d   = 3'd0;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 8'd0;
      sel_q     <= 3'd0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      cnt_q     <= 8'd0;
      ptr_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed vector bench for rr_arbiter8 (MAX_HOLD=4)
module tb_rr_arbiter8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  int total;
  int bad;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       pre;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] es,
                       input logic eb, input logic ep);
    total++;
    if (gnt !== eg || sel !== es || busy !== eb || preempt !== ep) begin
      bad++;
      $display("FAIL %s: got gnt=%h sel=%0d busy=%b preempt=%b, expected gnt=%h sel=%0d busy=%b preempt=%b",
               name, gnt, sel, busy, preempt, eg, es, eb, ep);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 8'h00;
    tick();
    check("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req   = 8'h00;

    vecs[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h84, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

    tick();
    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].pre);
    end

    // Everyone requesting, each owner releases after two granted cycles.
    do_reset();
    req = 8'hFF;
    tick();
    for (int i = 0; i <= 8; i++) begin
      automatic int o = i % 8;
      check($sformatf("rr_first%0d", i), 8'b1 << o, 3'(o), 1'b1, 1'b0);
      if (i == 8) break;
      req = 8'hFF;
      tick();
      check($sformatf("rr_second%0d", i), 8'b1 << o, 3'(o), 1'b1, 1'b0);
      req = 8'hFF & ~(8'b1 << o);
      tick();
      req = 8'hFF;
    end

    // Timeout preemption of owner 0 by requester 3.
    do_reset();
    req = 8'h01;
    tick();
    check("pre_hold0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h09;
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("pre_hold%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    tick();
    check("pre_switch", 8'h08, 3'd3, 1'b1, 1'b1);
    tick();
    check("pre_after", 8'h08, 3'd3, 1'b1, 1'b0);

    // Reset in the middle of a grant to requester 5.
    do_reset();
    req = 8'h20;
    tick();
    check("mid_grant", 8'h20, 3'd5, 1'b1, 1'b0);
    reset = 1'b1;
    req   = 8'h06;
    tick();
    check("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check("post_reset", 8'h02, 3'd1, 1'b1, 1'b0);

    // A lone requester is never preempted.
    do_reset();
    req = 8'h10;
    for (int i = 0; i < 100; i++) begin
      tick();
      check($sformatf("lone%0d", i), 8'h10, 3'd4, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, legal range 1..255: the maximum number of consecutive granted cycles an owner keeps while another requester waits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 8 bits: req[i]=1 means requester i wants the shared 8:1 mux path, held until finished.
REQ-005 SHALL have port gnt, output, 8 bits: one-hot grant, or all zero, registered.
REQ-006 SHALL have port sel, output, 3 bits: binary index of the owner; drives the 8:1 mux as sel[0]->sel0, sel[1]->sel1, sel[2]->sel2; registered.
REQ-007 SHALL have port busy, output, 1 bit: 1 while a grant is held (gnt!=0), registered.
REQ-008 SHALL have port preempt, output, 1 bit: one-cycle pulse in the cycle in which gnt first shows an owner installed by timeout preemption.

Function
REQ-009 SHALL implement two states: IDLE (gnt=0, busy=0) and OWNED (exactly one gnt bit set, busy=1).
REQ-010 SHALL hold a 3-bit round-robin pointer ptr; winner = first i with req[i]=1 searching ptr, ptr+1, ... modulo 8.
REQ-011 SHALL, in IDLE with req!=0 at an edge, enter OWNED with gnt=onehot(winner), sel=winner, hold counter cnt=0, ptr=winner+1 mod 8 (1-cycle request-to-grant latency).
REQ-012 SHALL, in IDLE with req=0, remain in IDLE with all outputs 0.
REQ-013 SHALL, in OWNED with req[owner]=0 (release), search req with the owner bit masked, starting at owner+1 mod 8. If a winner exists, install it back-to-back in the next cycle, with cnt=0 and ptr=winner+1 mod 8. Otherwise return to IDLE (gnt=0, busy=0 next cycle).
REQ-014 SHALL, in OWNED with req[owner]=1, increment cnt each cycle, saturating at MAX_HOLD-1.
REQ-015 SHALL preempt when all of the following hold: state OWNED, req[owner]=1, cnt==MAX_HOLD-1, and any other req bit is 1. On preemption: the new owner is selected as in REQ-013 (owner masked), cnt=0, and preempt=1 for exactly the first cycle of the new grant.
REQ-016 SHALL never preempt while no other requester is pending, regardless of hold length.
REQ-017 SHALL require a preempted owner to keep or re-assert req; it rejoins round-robin order normally.
REQ-018 SHALL keep gnt, sel and busy mutually consistent every cycle. In IDLE sel=0.
REQ-019 SHALL ignore req bits other than the owner's while in OWNED, except for preemption and release decisions.
REQ-020 SHALL make sel change only together with gnt, so the mux select is stable for the whole grant.

Reset
REQ-021 SHALL, with reset=1 at an edge, force next cycle: IDLE, gnt=0, sel=0, busy=0, preempt=0, cnt=0, ptr=0. This applies also mid-grant.
REQ-022 SHALL give reset priority over every other transition; the first arbitration after reset favours requester 0.

Verification
REQ-023 SHALL cover: reset, then req=0x01 at cycle 0 -> cycle 1: gnt=0x01, sel=0, busy=1, preempt=0.
REQ-024 SHALL cover: req=0xFF, each owner drops req for one cycle after 2 granted cycles, then re-asserts -> grant order 0,1,2,...,7,0 with no idle gap and preempt never 1.
REQ-025 SHALL cover: MAX_HOLD=4, req0 held, req3 asserted from cycle 1 -> gnt=0x01 for 4 cycles, then gnt=0x08, sel=3, preempt=1 for one cycle only.
REQ-026 SHALL cover: owner 7 releases with req=0x81 -> next cycle gnt=0x01, sel=0 (wrap-around).
REQ-027 SHALL cover: reset asserted while gnt=0x20, then req=0x06 -> after reset gnt=0x00, busy=0; next grant gnt=0x02.
REQ-028 SHALL cover: req=0x10 alone held for 100 cycles, MAX_HOLD=4 -> gnt=0x10 stable throughout, preempt never 1.
